// File: rtl/trap_sequencer_if.sv
// Trap-source, PSR/PC snapshot and trap-entry write-back bundle between the pipeline and trap_sequencer.
// The pipeline drives sources and snapshot on master; the sequencer returns strobes and data on slave.
interface trap_sequencer_if #(
   parameter int NWIN  = 8,
   parameter int CWP_W = 3
);
   logic             inst_boundary;
   logic             illegal_instr;
   logic             priv_instr;
   logic             win_save;
   logic             win_restore;
   logic             tcond;
   logic [6:0]       trap_num;
   logic [3:0]       irl;
   logic             psr_et;
   logic             psr_s;
   logic [3:0]       psr_pil;
   logic [CWP_W-1:0] psr_cwp;
   logic [NWIN-1:0]  wim;
   logic [31:0]      pc;
   logic [31:0]      npc;

   logic             stall;
   logic             trap_taken;
   logic             psr_we;
   logic             psr_new_et;
   logic             psr_new_ps;
   logic             psr_new_s;
   logic [CWP_W-1:0] psr_new_cwp;
   logic             rf_we;
   logic [4:0]       rf_waddr;
   logic [31:0]      rf_wdata;
   logic             tbr_we;
   logic [7:0]       tbr_tt;
   logic             pc_redirect;
   logic             error_mode;

   modport master (
      output inst_boundary, illegal_instr, priv_instr, win_save, win_restore, tcond,
             trap_num, irl, psr_et, psr_s, psr_pil, psr_cwp, wim, pc, npc,
      input  stall, trap_taken, psr_we, psr_new_et, psr_new_ps, psr_new_s, psr_new_cwp,
             rf_we, rf_waddr, rf_wdata, tbr_we, tbr_tt, pc_redirect, error_mode
   );

   modport slave (
      input  inst_boundary, illegal_instr, priv_instr, win_save, win_restore, tcond,
             trap_num, irl, psr_et, psr_s, psr_pil, psr_cwp, wim, pc, npc,
      output stall, trap_taken, psr_we, psr_new_et, psr_new_ps, psr_new_s, psr_new_cwp,
             rf_we, rf_waddr, rf_wdata, tbr_we, tbr_tt, pc_redirect, error_mode
   );
endinterface

// File: rtl/trap_sequencer.sv
// SPARC V8 trap entry: latches the top-priority trap at an instruction boundary, then PSR, %l1/%l2, TBR/redirect.
// Latency: accept at edge 0, trap_taken in cycle 1, vector in cycle 4; stall held in every non-IDLE state.
module trap_sequencer #(
   parameter int NWIN  = 8,
   parameter int CWP_W = 3
) (
   input logic             clk,
   input logic             rst_n,
   trap_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PSR_UPD  = 3'd1,
      SAVE_PC  = 3'd2,
      SAVE_NPC = 3'd3,
      VECTOR   = 3'd4,
      ERROR    = 3'd5
   } state_t;

   typedef struct packed {
      logic             stall;
      logic             trap_taken;
      logic             psr_we;
      logic             psr_new_et;
      logic             psr_new_ps;
      logic             psr_new_s;
      logic [CWP_W-1:0] psr_new_cwp;
      logic             rf_we;
      logic [4:0]       rf_waddr;
      logic [31:0]      rf_wdata;
      logic             tbr_we;
      logic [7:0]       tbr_tt;
      logic             pc_redirect;
      logic             error_mode;
   } out_t;

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       tt_q;
   logic [31:0]      pc_q;
   logic [31:0]      npc_q;
   logic             s_q;
   logic [CWP_W-1:0] cwp_q;
   logic [7:0]       tt_nxt;
   logic [31:0]      pc_nxt;
   logic [31:0]      npc_nxt;
   logic             s_nxt;
   logic [CWP_W-1:0] cwp_nxt;
   out_t             out_q;
   out_t             out_nxt;

   logic [CWP_W-1:0] cwp_dn;
   logic [CWP_W-1:0] cwp_up;
   logic [CWP_W-1:0] lat_cwp_dn;
   logic             ovf;
   logic             unf;
   logic             irq;
   logic             sync_trap;
   logic [7:0]       tt_sel;
   logic             accept;

   // Source evaluation against the current PSR snapshot
   always_comb begin
      cwp_dn    = (bus.psr_cwp == '0) ? CWP_W'(NWIN - 1) : bus.psr_cwp - 1'b1;
      cwp_up    = (bus.psr_cwp == CWP_W'(NWIN - 1)) ? '0 : bus.psr_cwp + 1'b1;
      ovf       = bus.win_save & bus.wim[cwp_dn];
      unf       = bus.win_restore & bus.wim[cwp_up];
      irq       = bus.psr_et & (bus.irl != 4'd0) &
                  ((bus.irl == 4'hF) | (bus.irl > bus.psr_pil));
      sync_trap = bus.illegal_instr | bus.priv_instr | ovf | unf | bus.tcond;
      if (bus.illegal_instr)    tt_sel = 8'h02;
      else if (bus.priv_instr)  tt_sel = 8'h03;
      else if (ovf)             tt_sel = 8'h05;
      else if (unf)             tt_sel = 8'h06;
      else if (bus.tcond)       tt_sel = {1'b1, bus.trap_num};
      else                      tt_sel = {4'h1, bus.irl};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.inst_boundary) begin
               if (sync_trap && !bus.psr_et) state_nxt = ERROR;
               else if (sync_trap || irq)    state_nxt = PSR_UPD;
            end
         end
         PSR_UPD:  state_nxt = SAVE_PC;
         SAVE_PC:  state_nxt = SAVE_NPC;
         SAVE_NPC: state_nxt = VECTOR;
         VECTOR:   state_nxt = IDLE;
         ERROR:    state_nxt = ERROR;
         default:  state_nxt = IDLE;
      endcase
   end

   // Trap context is captured only on the edge that enters PSR_UPD
   always_comb begin
      accept  = (state == IDLE) && (state_nxt == PSR_UPD);
      tt_nxt  = accept ? tt_sel       : tt_q;
      pc_nxt  = accept ? bus.pc       : pc_q;
      npc_nxt = accept ? bus.npc      : npc_q;
      s_nxt   = accept ? bus.psr_s    : s_q;
      cwp_nxt = accept ? bus.psr_cwp  : cwp_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_q  <= '0;
         pc_q  <= '0;
         npc_q <= '0;
         s_q   <= 1'b0;
         cwp_q <= '0;
      end else begin
         tt_q  <= tt_nxt;
         pc_q  <= pc_nxt;
         npc_q <= npc_nxt;
         s_q   <= s_nxt;
         cwp_q <= cwp_nxt;
      end
   end

   // Outputs decoded from the state being entered, so the register lines up with the state itself
   always_comb begin
      lat_cwp_dn = (cwp_nxt == '0) ? CWP_W'(NWIN - 1) : cwp_nxt - 1'b1;
      out_nxt    = '0;
      out_nxt.stall = (state_nxt != IDLE);
      case (state_nxt)
         PSR_UPD: begin
            out_nxt.trap_taken  = 1'b1;
            out_nxt.psr_we      = 1'b1;
            out_nxt.psr_new_et  = 1'b0;
            out_nxt.psr_new_ps  = s_nxt;
            out_nxt.psr_new_s   = 1'b1;
            out_nxt.psr_new_cwp = lat_cwp_dn;
         end
         SAVE_PC: begin
            out_nxt.rf_we    = 1'b1;
            out_nxt.rf_waddr = 5'd17;
            out_nxt.rf_wdata = pc_nxt;
         end
         SAVE_NPC: begin
            out_nxt.rf_we    = 1'b1;
            out_nxt.rf_waddr = 5'd18;
            out_nxt.rf_wdata = npc_nxt;
         end
         VECTOR: begin
            out_nxt.tbr_we      = 1'b1;
            out_nxt.tbr_tt      = tt_nxt;
            out_nxt.pc_redirect = 1'b1;
         end
         ERROR:   out_nxt.error_mode = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_nxt;
      end
   end

   assign bus.stall       = out_q.stall;
   assign bus.trap_taken  = out_q.trap_taken;
   assign bus.psr_we      = out_q.psr_we;
   assign bus.psr_new_et  = out_q.psr_new_et;
   assign bus.psr_new_ps  = out_q.psr_new_ps;
   assign bus.psr_new_s   = out_q.psr_new_s;
   assign bus.psr_new_cwp = out_q.psr_new_cwp;
   assign bus.rf_we       = out_q.rf_we;
   assign bus.rf_waddr    = out_q.rf_waddr;
   assign bus.rf_wdata    = out_q.rf_wdata;
   assign bus.tbr_we      = out_q.tbr_we;
   assign bus.tbr_tt      = out_q.tbr_tt;
   assign bus.pc_redirect = out_q.pc_redirect;
   assign bus.error_mode  = out_q.error_mode;
endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a trap-level reference model predicts every output cycle; directed cases pin literals.
module tb_trap_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   trap_sequencer_if #(.NWIN(8), .CWP_W(3)) bus ();
   trap_sequencer #(.NWIN(8), .CWP_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic        stall;
      logic        trap_taken;
      logic        psr_we;
      logic        et;
      logic        ps;
      logic        s;
      logic [2:0]  cwp;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        tbr_we;
      logic [7:0]  tt;
      logic        redirect;
      logic        err;
   } rec_t;

   int   checks = 0;
   int   passed = 0;
   rec_t exp_q[$];
   bit   m_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   // Returns trap type, -1 for no trap, -2 for error mode
   function automatic int model_tt();
      int  cwp = int'(bus.psr_cwp);
      int  irl = int'(bus.irl);
      bit  ovf = bus.win_save && bus.wim[(cwp + 7) % 8];
      bit  unf = bus.win_restore && bus.wim[(cwp + 1) % 8];
      bit  sync = bus.illegal_instr || bus.priv_instr || ovf || unf || bus.tcond;
      if (sync && !bus.psr_et) return -2;
      if (bus.illegal_instr) return 2;
      if (bus.priv_instr) return 3;
      if (ovf) return 5;
      if (unf) return 6;
      if (bus.tcond) return 128 + int'(bus.trap_num);
      if (bus.psr_et && irl != 0 && (irl == 15 || irl > int'(bus.psr_pil))) return 16 + irl;
      return -1;
   endfunction

   always @(negedge clk) begin
      rec_t act, cur;
      int   t;
      act = '{bus.stall, bus.trap_taken, bus.psr_we, bus.psr_new_et, bus.psr_new_ps, bus.psr_new_s,
              bus.psr_new_cwp, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.tbr_we, bus.tbr_tt,
              bus.pc_redirect, bus.error_mode};
      cur = '0;
      if (!rst_n) begin
         exp_q.delete();
         m_err = 1'b0;
      end else if (m_err) begin
         cur.stall = 1'b1;
         cur.err   = 1'b1;
      end else if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
      end
      check("cycle", 64'(act), 64'(cur));
      if (rst_n && !m_err && !cur.stall && bus.inst_boundary) begin
         t = model_tt();
         if (t == -2) m_err = 1'b1;
         else if (t >= 0) begin
            rec_t r;
            r = '0; r.stall = 1; r.trap_taken = 1; r.psr_we = 1; r.ps = bus.psr_s; r.s = 1;
            r.cwp = 3'((int'(bus.psr_cwp) + 7) % 8);
            exp_q.push_back(r);
            r = '0; r.stall = 1; r.rf_we = 1; r.waddr = 5'd17; r.wdata = bus.pc;
            exp_q.push_back(r);
            r = '0; r.stall = 1; r.rf_we = 1; r.waddr = 5'd18; r.wdata = bus.npc;
            exp_q.push_back(r);
            r = '0; r.stall = 1; r.tbr_we = 1; r.tt = 8'(t); r.redirect = 1;
            exp_q.push_back(r);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.inst_boundary = 0; bus.illegal_instr = 0; bus.priv_instr = 0;
      bus.win_save = 0; bus.win_restore = 0; bus.tcond = 0; bus.trap_num = '0;
      bus.irl = '0; bus.psr_et = 1; bus.psr_s = 0; bus.psr_pil = '0; bus.psr_cwp = '0;
      bus.wim = '0; bus.pc = '0; bus.npc = '0;
   endtask

   task automatic fire();
      bus.inst_boundary = 1;
      step();
      clr();
   endtask

   initial begin
      int err_cnt;
      clr();
      rst_n = 0;
      repeat (2) @(negedge clk);
      check("reset_stall", 64'(bus.stall), 64'(0));
      check("reset_taken", 64'(bus.trap_taken), 64'(0));
      step();
      rst_n = 1;
      step();

      // illegal outranks tcond; CWP 3 -> 2
      bus.illegal_instr = 1; bus.tcond = 1; bus.psr_cwp = 3'd3; bus.psr_s = 0;
      fire();
      @(negedge clk);
      check("t1_taken", 64'(bus.trap_taken), 64'(1));
      check("t1_cwp", 64'(bus.psr_new_cwp), 64'(2));
      check("t1_s_et_ps", 64'({bus.psr_new_s, bus.psr_new_et, bus.psr_new_ps}), 64'(3'b100));
      repeat (3) @(negedge clk);
      check("t1_tt", 64'(bus.tbr_tt), 64'(8'h02));
      @(negedge clk);
      check("t1_idle", 64'(bus.stall), 64'(0));

      // software trap, CWP wraps 0 -> 7
      bus.tcond = 1; bus.trap_num = 7'h05; bus.pc = 32'h100; bus.npc = 32'h104; bus.psr_s = 1;
      fire();
      @(negedge clk);
      check("t2_cwp", 64'(bus.psr_new_cwp), 64'(7));
      check("t2_ps", 64'(bus.psr_new_ps), 64'(1));
      @(negedge clk);
      check("t2_r17", 64'({bus.rf_waddr, bus.rf_wdata}), {27'd0, 5'd17, 32'h100});
      @(negedge clk);
      check("t2_r18", 64'({bus.rf_waddr, bus.rf_wdata}), {27'd0, 5'd18, 32'h104});
      @(negedge clk);
      check("t2_tt", 64'({bus.tbr_we, bus.pc_redirect, bus.tbr_tt}), 64'({2'b11, 8'h85}));
      @(negedge clk);
      check("t2_idle", 64'(bus.stall), 64'(0));

      // window overflow gated by WIM
      bus.win_save = 1; bus.psr_cwp = 3'd2; bus.wim = 8'h02;
      fire();
      repeat (4) @(negedge clk);
      check("t3_tt", 64'(bus.tbr_tt), 64'(8'h05));
      step();
      bus.win_save = 1; bus.psr_cwp = 3'd2; bus.wim = 8'h01;
      fire();
      @(negedge clk);
      check("t3_notrap", 64'(bus.stall), 64'(0));

      // interrupts
      bus.irl = 4'd5; bus.psr_pil = 4'd7;
      fire();
      @(negedge clk);
      check("t4_masked", 64'(bus.stall), 64'(0));
      step();
      bus.irl = 4'd15; bus.psr_pil = 4'd15;
      fire();
      repeat (4) @(negedge clk);
      check("t4_nmi_tt", 64'(bus.tbr_tt), 64'(8'h1F));
      step();
      bus.irl = 4'd9; bus.psr_et = 0;
      fire();
      @(negedge clk);
      check("t4_et0", 64'({bus.stall, bus.error_mode}), 64'(0));
      step();

      // sync trap with traps disabled is absorbing
      bus.tcond = 1; bus.psr_et = 0;
      fire();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t5_err", 64'({bus.error_mode, bus.stall, bus.psr_we, bus.rf_we, bus.tbr_we}), 64'(5'b11000));
      end
      @(posedge clk);
      #1 rst_n = 0;
      #1 check("t5_rst", 64'({bus.error_mode, bus.stall}), 64'(0));
      step();
      rst_n = 1;
      step();

      // reset in the middle of SAVE_PC
      bus.tcond = 1; bus.trap_num = 7'h11; bus.pc = 32'hDEAD_0000;
      fire();
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 0;
      #1 check("t6_abort", 64'({bus.stall, bus.rf_we, bus.rf_wdata}), 64'(0));
      step();
      rst_n = 1;
      step();
      bus.illegal_instr = 1; bus.psr_cwp = 3'd5;
      fire();
      @(negedge clk);
      check("t6_cwp", 64'(bus.psr_new_cwp), 64'(4));
      repeat (3) @(negedge clk);
      check("t6_tt", 64'(bus.tbr_tt), 64'(8'h02));
      step();

      // randomized traffic, reset out of error mode
      err_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (m_err && ++err_cnt > 4) begin
            clr();
            rst_n = 0;
            step();
            rst_n = 1;
            err_cnt = 0;
         end else begin
            bus.inst_boundary = ($urandom_range(0, 3) != 0);
            bus.illegal_instr = ($urandom_range(0, 15) == 0);
            bus.priv_instr    = ($urandom_range(0, 15) == 0);
            bus.win_save      = ($urandom_range(0, 5) == 0);
            bus.win_restore   = ($urandom_range(0, 5) == 0);
            bus.tcond         = ($urandom_range(0, 11) == 0);
            bus.trap_num      = 7'($urandom);
            bus.irl           = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            bus.psr_et        = ($urandom_range(0, 31) != 0);
            bus.psr_s         = 1'($urandom);
            bus.psr_pil       = 4'($urandom);
            bus.psr_cwp       = 3'($urandom);
            bus.wim           = 8'($urandom);
            bus.pc            = $urandom;
            bus.npc           = $urandom;
            step();
         end
      end
      clr();
      repeat (6) step();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
